// File: rtl/elink_test_seq_if.sv
// -----------------------------------------------------------------------------
// elink_test_seq_if
// Bundles the eMesh transmit and loopback-receive signals used by the elink
// test sequencer.
//   master : the sequencer side (drives tx packet, rx wait; samples tx wait
//            and the returned rx packet)
//   slave  : the elink/loopback side (the mirror image)
// Signals:
//   emesh_access_out/write_out/datamode_out/ctrlmode_out/dstaddr_out/
//   data_out/srcaddr_out : tx packet
//   emesh_wait_in        : tx backpressure
//   emesh_access_in/write_in/dstaddr_in/data_in : rx packet
//   emesh_wait_out       : rx backpressure
// -----------------------------------------------------------------------------
interface elink_test_seq_if;
   logic        emesh_access_out;
   logic        emesh_write_out;
   logic [1:0]  emesh_datamode_out;
   logic [3:0]  emesh_ctrlmode_out;
   logic [31:0] emesh_dstaddr_out;
   logic [31:0] emesh_data_out;
   logic [31:0] emesh_srcaddr_out;
   logic        emesh_wait_in;
   logic        emesh_access_in;
   logic        emesh_write_in;
   logic [31:0] emesh_dstaddr_in;
   logic [31:0] emesh_data_in;
   logic        emesh_wait_out;

   modport master (
      output emesh_access_out, emesh_write_out, emesh_datamode_out,
             emesh_ctrlmode_out, emesh_dstaddr_out, emesh_data_out,
             emesh_srcaddr_out, emesh_wait_out,
      input  emesh_wait_in, emesh_access_in, emesh_write_in,
             emesh_dstaddr_in, emesh_data_in
   );

   modport slave (
      input  emesh_access_out, emesh_write_out, emesh_datamode_out,
             emesh_ctrlmode_out, emesh_dstaddr_out, emesh_data_out,
             emesh_srcaddr_out, emesh_wait_out,
      output emesh_wait_in, emesh_access_in, emesh_write_in,
             emesh_dstaddr_in, emesh_data_in
   );
endinterface

// File: rtl/elink_test_seq.sv
// -----------------------------------------------------------------------------
// elink_test_seq
// Self-checking eMesh traffic source/sink for one elink channel. On start it
// sends NUM_PKTS write packets (address BASE_ADDR+4*i, data = LFSR after i
// steps from SEED) and checks the looped-back packets against an identical
// generator. done/error are sticky until reset.
// Ports:
//   aclk     : clock
//   reset    : synchronous active-high reset
//   start    : level, sampled only while idle
//   em       : eMesh tx/rx bundle (master modport)
//   done     : sticky test complete
//   error    : sticky failure
//   rx_count : packets received so far (saturating)
// -----------------------------------------------------------------------------
module elink_test_seq #(
   parameter int          NUM_PKTS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h8090_0000,
   parameter logic [31:0] SEED      = 32'h0000_0001,
   parameter logic [31:0] POLY      = 32'h8020_0003,
   parameter int          TIMEOUT   = 4096
) (
   input  logic                    aclk,
   input  logic                    reset,
   input  logic                    start,
   elink_test_seq_if.master        em,
   output logic                    done,
   output logic                    error,
   output logic [15:0]             rx_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEND   = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam logic [15:0] LAST_IDX = 16'(NUM_PKTS - 1);
   localparam logic [15:0] PKTS16   = 16'(NUM_PKTS);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   // Galois LFSR step shared by the tx generator and the rx reference.
   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      lfsr_step = (x >> 1) ^ (x[0] ? POLY : 32'h0000_0000);
   endfunction

   logic [1:0]  state_r;
   logic        access_r;
   logic [31:0] dstaddr_r;
   logic [31:0] data_r;
   logic [31:0] tx_lfsr_r;
   logic [15:0] tx_idx_r;
   logic [31:0] rx_lfsr_r;
   logic [15:0] rx_count_r;
   logic [31:0] tmo_r;
   logic        done_r;
   logic        error_r;
   logic        ran_r;      // a test has been started since reset

   logic        accept_s;
   logic        tx_last_s;
   logic [15:0] tx_idx_nxt_s;
   logic [31:0] tx_lfsr_nxt_s;
   logic [31:0] rx_exp_addr_s;
   logic        rx_mismatch_s;
   logic [15:0] rx_cnt_nxt_s;
   logic        tmo_hit_s;

   // Handshake, expected-packet and timeout decode for the current cycle.
   always_comb begin
      accept_s      = access_r & ~em.emesh_wait_in;
      tx_last_s     = (tx_idx_r == LAST_IDX);
      tx_idx_nxt_s  = tx_idx_r + 16'd1;
      tx_lfsr_nxt_s = lfsr_step(tx_lfsr_r);
      rx_exp_addr_s = BASE_ADDR + {14'd0, rx_count_r, 2'b00};
      rx_mismatch_s = ~em.emesh_write_in
                    | (em.emesh_dstaddr_in != rx_exp_addr_s)
                    | (em.emesh_data_in != rx_lfsr_r);
      // rx count including this cycle's packet, saturating at all-ones
      if (em.emesh_access_in && (rx_count_r != 16'hFFFF)) begin
         rx_cnt_nxt_s = rx_count_r + 16'd1;
      end else begin
         rx_cnt_nxt_s = rx_count_r;
      end
      tmo_hit_s = ~em.emesh_access_in & (tmo_r == TMO_LAST);
   end

   // Sequencer FSM: tx generator, loopback checker, timeout and status flags.
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         access_r   <= 1'b0;
         dstaddr_r  <= 32'h0000_0000;
         data_r     <= 32'h0000_0000;
         tx_lfsr_r  <= SEED;
         tx_idx_r   <= 16'd0;
         rx_lfsr_r  <= SEED;
         rx_count_r <= 16'd0;
         tmo_r      <= 32'd0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         ran_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // stray packets are only an error once a test has been run
               if (em.emesh_access_in && ran_r) begin
                  error_r <= 1'b1;
               end
               if (start) begin
                  state_r   <= ST_SEND;
                  access_r  <= 1'b1;
                  dstaddr_r <= BASE_ADDR;
                  data_r    <= tx_lfsr_r;
                  ran_r     <= 1'b1;
               end
            end
            ST_SEND, ST_DRAIN: begin
               // checker runs alongside tx: loopback may return early
               if (em.emesh_access_in) begin
                  if (rx_mismatch_s) begin
                     error_r <= 1'b1;
                  end
                  rx_count_r <= rx_cnt_nxt_s;
                  rx_lfsr_r  <= lfsr_step(rx_lfsr_r);
                  tmo_r      <= 32'd0;
               end else begin
                  tmo_r <= tmo_r + 32'd1;
               end

               if (tmo_hit_s) begin
                  state_r  <= ST_FINISH;
                  access_r <= 1'b0;
                  error_r  <= 1'b1;
                  done_r   <= 1'b1;
               end else if (state_r == ST_SEND) begin
                  if (accept_s) begin
                     if (tx_last_s) begin
                        access_r <= 1'b0;
                        // last rx may coincide with the last tx acceptance
                        if (rx_cnt_nxt_s == PKTS16) begin
                           state_r <= ST_FINISH;
                           done_r  <= 1'b1;
                        end else begin
                           state_r <= ST_DRAIN;
                        end
                     end else begin
                        tx_idx_r  <= tx_idx_nxt_s;
                        tx_lfsr_r <= tx_lfsr_nxt_s;
                        dstaddr_r <= BASE_ADDR + {14'd0, tx_idx_nxt_s, 2'b00};
                        data_r    <= tx_lfsr_nxt_s;
                     end
                  end
               end else if (rx_cnt_nxt_s == PKTS16) begin
                  // done registers on the same edge that takes the last packet
                  state_r <= ST_FINISH;
                  done_r  <= 1'b1;
               end
            end
            ST_FINISH: begin
               if (em.emesh_access_in) begin
                  error_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign em.emesh_access_out   = access_r;
   assign em.emesh_write_out    = 1'b1;
   assign em.emesh_datamode_out = 2'b10;
   assign em.emesh_ctrlmode_out = 4'h0;
   assign em.emesh_dstaddr_out  = dstaddr_r;
   assign em.emesh_data_out     = data_r;
   assign em.emesh_srcaddr_out  = 32'h0000_0000;
   assign em.emesh_wait_out     = 1'b0;

   assign done     = done_r;
   assign error    = error_r;
   assign rx_count = rx_count_r;

endmodule

// File: tb/tb_elink_test_seq.sv
// -----------------------------------------------------------------------------
// tb_elink_test_seq
// Directed bench for elink_test_seq with a one-cycle loopback model
// (accepted tx packet reappears on rx the following cycle), optional data
// corruption, dropped and injected rx packets.
// -----------------------------------------------------------------------------
module tb_elink_test_seq;

   localparam logic [31:0] BASE = 32'h8090_0000;
   localparam logic [31:0] POLY = 32'h8020_0003;

   logic        aclk;
   logic        reset;
   logic        start;
   logic        done;
   logic        error;
   logic [15:0] rx_count;

   elink_test_seq_if ifc ();

   elink_test_seq #(
      .NUM_PKTS  (16),
      .BASE_ADDR (32'h8090_0000),
      .SEED      (32'h0000_0001),
      .POLY      (32'h8020_0003),
      .TIMEOUT   (64)
   ) dut (
      .aclk     (aclk),
      .reset    (reset),
      .start    (start),
      .em       (ifc.master),
      .done     (done),
      .error    (error),
      .rx_count (rx_count)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_errors = 0;

   // loopback / scoreboard state
   int          tx_idx;
   logic [31:0] tx_lfsr;
   int          rx_idx;
   logic        pend_v;
   logic [31:0] pend_a;
   logic [31:0] pend_d;
   int          corrupt_idx;
   int          drop_idx;
   logic        corrupt_sent;
   logic        extra_rx;

   typedef struct {
      logic        start;
      logic        acc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] rx;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      lfsr_next = (x >> 1) ^ (x[0] ? POLY : 32'h0000_0000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      tx_idx       = 0;
      tx_lfsr      = 32'h0000_0001;
      rx_idx       = 0;
      pend_v       = 1'b0;
      corrupt_idx  = -1;
      drop_idx     = -1;
      corrupt_sent = 1'b0;
      extra_rx     = 1'b0;
   endtask

   // One clock: score any tx acceptance, then drive the loopback rx side.
   task automatic tick();
      pend_v = 1'b0;
      if (ifc.emesh_access_out && !ifc.emesh_wait_in && !reset) begin
         chk("tx_addr", ifc.emesh_dstaddr_out, BASE + 32'(4 * tx_idx));
         chk("tx_data", ifc.emesh_data_out, tx_lfsr);
         pend_v  = 1'b1;
         pend_a  = ifc.emesh_dstaddr_out;
         pend_d  = ifc.emesh_data_out;
         tx_idx  = tx_idx + 1;
         tx_lfsr = lfsr_next(tx_lfsr);
      end
      @(posedge aclk);
      #1;
      ifc.emesh_access_in  = 1'b0;
      ifc.emesh_write_in   = 1'b0;
      ifc.emesh_dstaddr_in = 32'h0000_0000;
      ifc.emesh_data_in    = 32'h0000_0000;
      if (extra_rx) begin
         ifc.emesh_access_in  = 1'b1;
         ifc.emesh_write_in   = 1'b1;
         ifc.emesh_dstaddr_in = BASE + 32'h0000_0040;
         ifc.emesh_data_in    = 32'h1234_5678;
         extra_rx = 1'b0;
      end else if (pend_v) begin
         if (rx_idx != drop_idx) begin
            ifc.emesh_access_in  = 1'b1;
            ifc.emesh_write_in   = 1'b1;
            ifc.emesh_dstaddr_in = pend_a;
            ifc.emesh_data_in    = pend_d;
            if (rx_idx == corrupt_idx) begin
               ifc.emesh_data_in = pend_d ^ 32'h0000_0001;
               corrupt_sent = 1'b1;
            end
         end
         rx_idx = rx_idx + 1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      ifc.emesh_wait_in = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_clear();
   endtask

   task automatic run_until_done(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (done) break;
         tick();
      end
      chk("done_within_budget", {31'd0, done}, 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      ifc.emesh_wait_in    = 1'b0;
      ifc.emesh_access_in  = 1'b0;
      ifc.emesh_write_in   = 1'b0;
      ifc.emesh_dstaddr_in = 32'h0000_0000;
      ifc.emesh_data_in    = 32'h0000_0000;
      model_clear();

      // {start, access_out, dstaddr_out, data_out, rx_count} after each clock
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 16'd0};
      vecs[1] = '{1'b1, 1'b1, 32'h8090_0000, 32'h0000_0001, 16'd0};
      vecs[2] = '{1'b0, 1'b1, 32'h8090_0004, 32'h8020_0003, 16'd0};
      vecs[3] = '{1'b0, 1'b1, 32'h8090_0008, 32'hC030_0002, 16'd1};
      vecs[4] = '{1'b0, 1'b1, 32'h8090_000C, 32'h6018_0001, 16'd2};
      vecs[5] = '{1'b0, 1'b1, 32'h8090_0010, 32'hB02C_0003, 16'd3};
      vecs[6] = '{1'b0, 1'b1, 32'h8090_0014, 32'hD836_0002, 16'd4};
      vecs[7] = '{1'b0, 1'b1, 32'h8090_0018, 32'h6C1B_0001, 16'd5};
      vecs[8] = '{1'b0, 1'b1, 32'h8090_001C, 32'hB62D_8003, 16'd6};

      // ---- Test 1: plain loopback, table-driven first packets -------------
      do_reset();
      chk("rst_access", {31'd0, ifc.emesh_access_out}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_error",  {31'd0, error}, 32'd0);
      chk("rst_rx",     {16'd0, rx_count}, 32'd0);
      chk("const_datamode", {30'd0, ifc.emesh_datamode_out}, 32'd2);
      chk("const_write",    {31'd0, ifc.emesh_write_out}, 32'd1);
      for (int i = 0; i < 9; i++) begin
         start = vecs[i].start;
         tick();
         chk($sformatf("v%0d_access", i), {31'd0, ifc.emesh_access_out}, {31'd0, vecs[i].acc});
         chk($sformatf("v%0d_addr", i), ifc.emesh_dstaddr_out, vecs[i].addr);
         chk($sformatf("v%0d_data", i), ifc.emesh_data_out, vecs[i].data);
         chk($sformatf("v%0d_rx", i), {16'd0, rx_count}, {16'd0, vecs[i].rx});
         chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd0);
      end
      for (int i = 0; i < 9; i++) tick();
      chk("t1_access_low", {31'd0, ifc.emesh_access_out}, 32'd0);
      chk("t1_done_early", {31'd0, done}, 32'd0);
      chk("t1_rx15", {16'd0, rx_count}, 32'd15);
      tick();
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_error", {31'd0, error}, 32'd0);
      chk("t1_rx16", {16'd0, rx_count}, 32'd16);
      chk("t1_tx_count", 32'(tx_idx), 32'd16);
      // extra packet after done
      extra_rx = 1'b1;
      tick();
      chk("t5_error_before", {31'd0, error}, 32'd0);
      tick();
      chk("t5_error", {31'd0, error}, 32'd1);
      chk("t5_done", {31'd0, done}, 32'd1);

      // ---- Test 2: backpressure on packet 3 -------------------------------
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("t2_pkt3_addr", ifc.emesh_dstaddr_out, 32'h8090_000C);
      ifc.emesh_wait_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_access", {31'd0, ifc.emesh_access_out}, 32'd1);
         chk("t2_hold_addr", ifc.emesh_dstaddr_out, 32'h8090_000C);
         chk("t2_hold_data", ifc.emesh_data_out, 32'h6018_0001);
      end
      ifc.emesh_wait_in = 1'b0;
      run_until_done(60);
      chk("t2_error", {31'd0, error}, 32'd0);
      chk("t2_rx16", {16'd0, rx_count}, 32'd16);
      chk("t2_tx_count", 32'(tx_idx), 32'd16);

      // ---- Test 3: corrupt packet 7 data ----------------------------------
      do_reset();
      corrupt_idx = 7;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (corrupt_sent) break;
         tick();
      end
      chk("t3_corrupt_sent", {31'd0, corrupt_sent}, 32'd1);
      chk("t3_error_before", {31'd0, error}, 32'd0);
      tick();
      chk("t3_error", {31'd0, error}, 32'd1);
      chk("t3_done_early", {31'd0, done}, 32'd0);
      run_until_done(40);
      chk("t3_rx16", {16'd0, rx_count}, 32'd16);
      chk("t3_error_sticky", {31'd0, error}, 32'd1);

      // ---- Test 4: 16th rx packet dropped, timeout 64 ---------------------
      do_reset();
      drop_idx = 15;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rx_count == 16'd15) break;
         tick();
      end
      chk("t4_rx15", {16'd0, rx_count}, 32'd15);
      for (int i = 0; i < 63; i++) tick();
      chk("t4_done_early", {31'd0, done}, 32'd0);
      chk("t4_error_early", {31'd0, error}, 32'd0);
      tick();
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_error", {31'd0, error}, 32'd1);
      chk("t4_rx_final", {16'd0, rx_count}, 32'd15);

      // ---- Test 6: reset at packet 5, then a clean rerun ------------------
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ifc.emesh_dstaddr_out == 32'h8090_0014) break;
         tick();
      end
      chk("t6_at_pkt5", ifc.emesh_dstaddr_out, 32'h8090_0014);
      reset = 1'b1;
      tick();
      chk("t6_rst_access", {31'd0, ifc.emesh_access_out}, 32'd0);
      chk("t6_rst_addr", ifc.emesh_dstaddr_out, 32'd0);
      chk("t6_rst_data", ifc.emesh_data_out, 32'd0);
      chk("t6_rst_done", {31'd0, done}, 32'd0);
      chk("t6_rst_error", {31'd0, error}, 32'd0);
      chk("t6_rst_rx", {16'd0, rx_count}, 32'd0);
      reset = 1'b0;
      model_clear();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_replay_addr", ifc.emesh_dstaddr_out, 32'h8090_0000);
      chk("t6_replay_data", ifc.emesh_data_out, 32'h0000_0001);
      run_until_done(60);
      chk("t6_error", {31'd0, error}, 32'd0);
      chk("t6_rx16", {16'd0, rx_count}, 32'd16);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
